// File: rtl/load_unit_if.sv
// Bus bundle between the load unit, the load buffer, the data memory and the CDB.
// The slave modport is the load unit; the master modport is its environment.
interface load_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  // Issue side (load buffer)
  logic              valid_in;
  logic [31:0]       addr_in;
  logic [2:0]        rob_ix_in;
  logic [2:0]        funct3_in;
  logic              read_out;
  logic              flush_in;
  // Data memory read port
  logic              mem_en_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [31:0]       mem_rdata_in;
  // CDB side
  logic              valid_out;
  logic [31:0]       result_out;
  logic [2:0]        rob_ix_out;
  logic              fault_out;
  logic              cdb_ready_in;

  modport slave (
    input  valid_in, addr_in, rob_ix_in, funct3_in, flush_in, mem_rdata_in, cdb_ready_in,
    output read_out, mem_en_out, mem_addr_out, valid_out, result_out, rob_ix_out, fault_out
  );

  modport master (
    output valid_in, addr_in, rob_ix_in, funct3_in, flush_in, mem_rdata_in, cdb_ready_in,
    input  read_out, mem_en_out, mem_addr_out, valid_out, result_out, rob_ix_out, fault_out
  );
endinterface

// File: rtl/load_unit.sv
// Load unit: issues word reads to a fixed-latency memory, extracts and extends the
// addressed byte/half/word, and queues results in order for the CDB. An occupancy
// counter (pipeline + FIFO) provides credit-based backpressure to the load buffer.
module load_unit #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned RESP_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  load_unit_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic       valid;
    logic [2:0] rob;
    logic [2:0] f3;
    logic [1:0] off;
    logic       fault;
  } stage_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  rob;
    logic        fault;
  } entry_t;

  stage_t          pipe_q [MEM_LATENCY];
  stage_t          tail;
  entry_t          fifo_q [RESP_DEPTH];
  entry_t          push_entry;
  entry_t          head;
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            accept, fault, push, pop, empty;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            unused_addr;

  assign unused_addr = ^bus.addr_in[31:ADDR_W+2];

  // Classify the offered load and decide whether it is accepted this cycle
  always_comb begin
    fault = 1'b1;
    unique case (bus.funct3_in)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = bus.addr_in[0];
      3'b010:         fault = |bus.addr_in[1:0];
      default:        fault = 1'b1;
    endcase
    // Gated by reset so nothing is accepted while reset is held
    accept = rst_in && bus.valid_in && !bus.flush_in && (count_q < CntW'(RESP_DEPTH));
  end

  assign bus.read_out     = accept;
  assign bus.mem_en_out   = accept && !fault;
  assign bus.mem_addr_out = bus.addr_in[ADDR_W+1:2];

  // Latency pipeline; faulting loads ride along to keep completion in order
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else if (bus.flush_in) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: accept, rob: bus.rob_ix_in, f3: bus.funct3_in,
                     off: bus.addr_in[1:0], fault: fault};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Extract and extend the addressed field from the returning memory word
  always_comb begin
    tail = pipe_q[MEM_LATENCY-1];
    unique case (tail.off)
      2'd0:    byte_sel = bus.mem_rdata_in[7:0];
      2'd1:    byte_sel = bus.mem_rdata_in[15:8];
      2'd2:    byte_sel = bus.mem_rdata_in[23:16];
      default: byte_sel = bus.mem_rdata_in[31:24];
    endcase
    half_sel = tail.off[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];
    push_entry.rob   = tail.rob;
    push_entry.fault = tail.fault;
    push_entry.data  = '0;
    if (!tail.fault) begin
      unique case (tail.f3)
        3'b000:  push_entry.data = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  push_entry.data = {24'h0, byte_sel};
        3'b001:  push_entry.data = {{16{half_sel[15]}}, half_sel};
        3'b101:  push_entry.data = {16'h0, half_sel};
        3'b010:  push_entry.data = bus.mem_rdata_in;
        default: push_entry.data = '0;
      endcase
    end
    push = tail.valid;
  end

  // Result FIFO head and pop handshake
  always_comb begin
    empty          = (wr_ptr_q == rd_ptr_q);
    head           = fifo_q[rd_ptr_q[PtrW-1:0]];
    pop            = !empty && bus.cdb_ready_in;
    bus.valid_out  = !empty;
    bus.result_out = empty ? 32'h0 : head.data;
    bus.rob_ix_out = empty ? 3'h0  : head.rob;
    bus.fault_out  = !empty && head.fault;
  end

  // FIFO storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk_in) begin
    if (push && !bus.flush_in) fifo_q[wr_ptr_q[PtrW-1:0]] <= push_entry;
  end

  // Occupancy: +1 on accept, -1 on pop; a same-cycle pop is not credited to accept
  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CntW'(1);
    else if (!accept && pop) count_d = count_q - CntW'(1);
    if (bus.flush_in)        count_d = '0;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, push};
      rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, pop};
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus random traffic, checked
// against a queue-based model of accepted loads and completed results.
module tb_load_unit;
  localparam int unsigned L  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 10;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_unit_if #(.ADDR_W(AW)) bus ();

  load_unit #(
    .MEM_LATENCY(L),
    .RESP_DEPTH (D),
    .ADDR_W     (AW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  // Memory model: data arrives two cycles after the enable; garbage otherwise
  logic [31:0]   mem [1024];
  logic          a1_v = 1'b0;
  logic [AW-1:0] a1   = '0;
  always @(posedge clk) begin
    bus.mem_rdata_in <= a1_v ? mem[a1] : $urandom;
    a1_v             <= bus.mem_en_out;
    a1               <= bus.mem_addr_out;
  end

  typedef struct {
    logic [2:0]  rob;
    logic [31:0] res;
    logic        fault;
    int          due;
  } exp_t;

  exp_t inflight[$];
  exp_t fifo[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic acc;
  int   idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Returns {fault, result} from the architectural load rules
  function automatic logic [32:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] w);
    logic [31:0] b, h;
    logic        flt;
    b   = w >> (8 * a[1:0]);
    h   = w >> (16 * a[1]);
    flt = (f3 inside {3'b011, 3'b110, 3'b111}) || ((f3 inside {LH, LHU}) && a[0]) ||
          (f3 == LW && a[1:0] != 2'b00);
    if (flt) return {1'b1, 32'h0};
    case (f3)
      LB:      return {1'b0, 32'(int'($signed(b[7:0])))};
      LBU:     return {1'b0, 24'h0, b[7:0]};
      LH:      return {1'b0, 32'(int'($signed(h[15:0])))};
      LHU:     return {1'b0, 16'h0, h[15:0]};
      default: return {1'b0, w};
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".valid_out"},  32'(bus.valid_out),  32'h0);
    chk({tag, ".result_out"}, bus.result_out,      32'h0);
    chk({tag, ".rob_ix_out"}, 32'(bus.rob_ix_out), 32'h0);
    chk({tag, ".fault_out"},  32'(bus.fault_out),  32'h0);
    chk({tag, ".mem_en_out"}, 32'(bus.mem_en_out), 32'h0);
    chk({tag, ".read_out"},   32'(bus.read_out),   32'h0);
  endtask

  // One cycle: drive inputs at the falling edge, check mid-cycle, advance the model
  task automatic step(input logic v, input logic [31:0] a, input logic [2:0] rob,
                      input logic [2:0] f3, input logic rdy, input logic fl, output logic rd);
    logic        ev;
    int          occ;
    logic [32:0] m;
    exp_t        e;
    @(negedge clk);
    bus.valid_in     = v;
    bus.addr_in      = a;
    bus.rob_ix_in    = rob;
    bus.funct3_in    = f3;
    bus.cdb_ready_in = rdy;
    bus.flush_in     = fl;
    #1;
    ev = (fifo.size() != 0);
    chk("valid_out", 32'(bus.valid_out), 32'(ev));
    if (ev) begin
      chk("rob_ix_out", 32'(bus.rob_ix_out), 32'(fifo[0].rob));
      chk("result_out", bus.result_out, fifo[0].res);
      chk("fault_out",  32'(bus.fault_out), 32'(fifo[0].fault));
    end
    occ = inflight.size() + fifo.size();
    rd  = v && !fl && (occ < D);
    m   = model(f3, a, mem[a[AW+1:2]]);
    chk("read_out",     32'(bus.read_out),   32'(rd));
    chk("mem_en_out",   32'(bus.mem_en_out), 32'(rd && !m[32]));
    chk("mem_addr_out", 32'(bus.mem_addr_out), 32'(a[AW+1:2]));
    if (fl) begin
      inflight.delete();
      fifo.delete();
    end else begin
      if (ev && rdy) void'(fifo.pop_front());
      if (inflight.size() != 0 && inflight[0].due == cyc) fifo.push_back(inflight.pop_front());
      if (rd) begin
        e.rob   = rob;
        e.res   = m[31:0];
        e.fault = m[32];
        e.due   = cyc + L;
        inflight.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'h0, LB, 1'b1, 1'b0, r);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[16] = 32'h8070F0A5;

    // Reset held with a load offered: nothing accepted, outputs zero
    bus.valid_in     = 1'b1;
    bus.addr_in      = 32'h40;
    bus.rob_ix_in    = 3'd1;
    bus.funct3_in    = LW;
    bus.flush_in     = 1'b0;
    bus.cdb_ready_in = 1'b1;
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;

    // Back-to-back extraction from word 0x8070F0A5
    step(1'b1, 32'h40, 3'd1, LB,  1'b1, 1'b0, acc);
    step(1'b1, 32'h41, 3'd2, LBU, 1'b1, 1'b0, acc);
    step(1'b1, 32'h42, 3'd3, LH,  1'b1, 1'b0, acc);
    step(1'b1, 32'h40, 3'd4, LW,  1'b1, 1'b0, acc);
    idle(6);

    // Faulting loads interleaved with good ones
    step(1'b1, 32'h44, 3'd5, LW,     1'b1, 1'b0, acc);
    step(1'b1, 32'h42, 3'd6, LW,     1'b1, 1'b0, acc);
    step(1'b1, 32'h40, 3'd7, 3'b011, 1'b1, 1'b0, acc);
    step(1'b1, 32'h43, 3'd0, LBU,    1'b1, 1'b0, acc);
    step(1'b1, 32'h47, 3'd1, LHU,    1'b1, 1'b0, acc);
    step(1'b1, 32'h46, 3'd2, LH,     1'b1, 1'b0, acc);
    idle(6);

    // Backpressure: six loads offered, CDB stalled, then released
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(idx < 6, 32'h80 + 32'(4 * idx), 3'(idx), LW, c >= 8, 1'b0, acc);
      if (acc) idx++;
    end
    chk("backpressure.all_accepted", 32'(idx), 32'd6);
    idle(6);

    // Flush with one result queued and two loads in flight
    step(1'b1, 32'h40, 3'd1, LB,  1'b0, 1'b0, acc);
    step(1'b1, 32'h41, 3'd2, LB,  1'b0, 1'b0, acc);
    step(1'b1, 32'h42, 3'd3, LB,  1'b0, 1'b0, acc);
    step(1'b1, 32'h43, 3'd4, LB,  1'b0, 1'b1, acc);
    step(1'b1, 32'h42, 3'd5, LHU, 1'b1, 1'b0, acc);
    idle(6);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
    end
    idle(6);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 3'(i), LW, 1'b1, 1'b0, acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    inflight.delete();
    fifo.delete();
    @(negedge clk);
    bus.valid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(8);
    step(1'b1, 32'h45, 3'd6, LBU, 1'b1, 1'b0, acc);
    step(1'b1, 32'h40, 3'd7, LW,  1'b1, 1'b0, acc);
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
